// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter.
// Holds the arbiter state encodings, the default fill length and a helper
// that sizes the beat counter. Imported by mem_arbiter and arb_beat_cnt.
package mem_arb_defs;

    localparam int unsigned BEATS_DEF = 8;
    localparam int unsigned ST_W      = 2;

    localparam logic [ST_W-1:0] IDLE    = 2'd0;
    localparam logic [ST_W-1:0] I_FILL  = 2'd1;
    localparam logic [ST_W-1:0] D_FILL  = 2'd2;
    localparam logic [ST_W-1:0] D_WRITE = 2'd3;

    // Counter width for a power-of-two beat count; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_beat_cnt.sv
// arb_beat_cnt: counts data-valid beats of one block fill.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   inc       - a beat arrived this cycle
//   clr       - return the count to zero (takes precedence over inc)
//   last      - this beat is the final one of the block (count==BEATS-1 && inc)
module arb_beat_cnt
    import mem_arb_defs::*;
#(
    parameter int unsigned BEATS = BEATS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic last
);

    localparam int unsigned       CNT_W   = cnt_width(BEATS);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] count;

    // Beat count register
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = inc && (count == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares main memory between the I-cache fill FSM and the
// D-cache (fills plus write-through stores). Each transaction runs to
// completion: a BEATS-strobe block fill or a one-cycle word write.
// Build option: define ARB_RR_EN for round-robin between simultaneous fill
// requests; otherwise D-cache fills have fixed priority over I-cache fills.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   icache_req, icache_addr        - I-cache fill request and address
//   dcache_req, dcache_addr        - D-cache fill request and address
//   dcache_wr, dcache_wdata        - D-cache store request and data
//   mem_data_valid                 - memory read-data strobe
//   icache_grant, dcache_grant     - current fill owner
//   icache_data_valid,
//   dcache_data_valid              - strobe routed to the owner only
//   wr_ack                         - store accepted this cycle
//   mem_rd_en, mem_wr_en,
//   mem_addr, mem_wdata            - memory command
module mem_arbiter
    import mem_arb_defs::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BEATS  = BEATS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_req,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_wr,
    input  logic [DATA_W-1:0] dcache_wdata,
    input  logic              mem_data_valid,
    output logic              icache_grant,
    output logic              dcache_grant,
    output logic              icache_data_valid,
    output logic              dcache_data_valid,
    output logic              wr_ack,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nx;
    logic            last_d;
    logic            last_d_nx;
    logic            cnt_inc;
    logic            cnt_last;

    // Strobes only count while a fill owns memory; stray strobes are dropped.
    assign cnt_inc = mem_data_valid && ((state == I_FILL) || (state == D_FILL));

    arb_beat_cnt #(
        .BEATS (BEATS)
    ) u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc),
        .clr  (cnt_last),
        .last (cnt_last)
    );

    // State and last-owner registers; I-cache is favoured after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            state  <= state_nx;
            last_d <= last_d_nx;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nx          = state;
        last_d_nx         = last_d;
        icache_grant      = 1'b0;
        dcache_grant      = 1'b0;
        icache_data_valid = 1'b0;
        dcache_data_valid = 1'b0;
        wr_ack            = 1'b0;
        mem_rd_en         = 1'b0;
        mem_wr_en         = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;

        case (state)
            IDLE: begin
                if (dcache_wr) begin
                    state_nx = D_WRITE;
                end else if (icache_req && dcache_req) begin
`ifdef ARB_RR_EN
                    state_nx = last_d ? I_FILL : D_FILL;
`else
                    state_nx = D_FILL;
`endif
                end else if (dcache_req) begin
                    state_nx = D_FILL;
                end else if (icache_req) begin
                    state_nx = I_FILL;
                end
            end

            I_FILL: begin
                icache_grant      = 1'b1;
                mem_rd_en         = 1'b1;
                mem_addr          = icache_addr;
                icache_data_valid = mem_data_valid;
                if (cnt_last) begin
                    state_nx  = IDLE;
                    last_d_nx = 1'b0;
                end
            end

            D_FILL: begin
                dcache_grant      = 1'b1;
                mem_rd_en         = 1'b1;
                mem_addr          = dcache_addr;
                dcache_data_valid = mem_data_valid;
                if (cnt_last) begin
                    state_nx  = IDLE;
                    last_d_nx = 1'b1;
                end
            end

            D_WRITE: begin
                mem_wr_en = 1'b1;
                mem_addr  = dcache_addr;
                mem_wdata = dcache_wdata;
                wr_ack    = 1'b1;
                state_nx  = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic.
// A transaction-level reference model predicts every grant start, routed
// beat and store; a separate monitor compares DUT activity with that queue.
module tb_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned NB = 8;

    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;
    localparam int OWN_W    = 3;

    localparam int EV_GRANT = 0;
    localparam int EV_BEAT  = 1;
    localparam int EV_WRITE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          icache_req = 1'b0;
    logic [AW-1:0] icache_addr = '0;
    logic          dcache_req = 1'b0;
    logic [AW-1:0] dcache_addr = '0;
    logic          dcache_wr = 1'b0;
    logic [DW-1:0] dcache_wdata = '0;
    logic          mem_data_valid = 1'b0;
    logic          icache_grant;
    logic          dcache_grant;
    logic          icache_data_valid;
    logic          dcache_data_valid;
    logic          wr_ack;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB)) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_req        (icache_req),
        .icache_addr       (icache_addr),
        .dcache_req        (dcache_req),
        .dcache_addr       (dcache_addr),
        .dcache_wr         (dcache_wr),
        .dcache_wdata      (dcache_wdata),
        .mem_data_valid    (mem_data_valid),
        .icache_grant      (icache_grant),
        .dcache_grant      (dcache_grant),
        .icache_data_valid (icache_data_valid),
        .dcache_data_valid (dcache_data_valid),
        .wr_ack            (wr_ack),
        .mem_rd_en         (mem_rd_en),
        .mem_wr_en         (mem_wr_en),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata)
    );

    typedef struct {
        int            kind;
        int            cyc;
        logic [6:0]    sig;   // {igrant,dgrant,rd_en,wr_en,idv,ddv,wr_ack}
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Values applied to the DUT at the next negedge
    logic          nx_rst = 1'b1, nx_ireq = 1'b0, nx_dreq = 1'b0, nx_dwr = 1'b0, nx_strobe = 1'b0;
    logic [AW-1:0] nx_iaddr = '0, nx_daddr = '0;
    logic [DW-1:0] nx_wdata = '0;

    // Reference model: who owns memory and how many beats it has received
    int m_own    = OWN_NONE;
    int m_beats  = 0;
    bit m_last_d = 1'b1;
    bit m_fresh  = 1'b0;
    int n_fills  = 0;
    bit i_done = 1'b0, d_done = 1'b0, w_done = 1'b0;

    // Direct observations from the driver side
    int            idv_cnt = 0, ddv_cnt = 0, wr_cnt = 0, last_idv_cyc = 0, wr_cyc = 0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_data = '0;
    bit            drv_pg = 1'b0;
    int            ord[$];

    function automatic void push(input int kind, input logic [6:0] sig,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_t e;
        e.kind = kind; e.cyc = cyc; e.sig = sig; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endfunction

    // Predict this cycle's activity, then advance across the coming edge
    task automatic model_cycle();
        logic [6:0] s;
        if (m_own == OWN_I || m_own == OWN_D) begin
            s = (m_own == OWN_I) ? 7'b1010000 : 7'b0110000;
            if (mem_data_valid) s = s | ((m_own == OWN_I) ? 7'b0000100 : 7'b0000010);
            if (m_fresh) push(EV_GRANT, s, (m_own == OWN_I) ? icache_addr : dcache_addr, '0);
            if (mem_data_valid) begin
                push(EV_BEAT, s, (m_own == OWN_I) ? icache_addr : dcache_addr, '0);
                m_beats++;
            end
        end else if (m_own == OWN_W) begin
            push(EV_WRITE, 7'b0001001, dcache_addr, dcache_wdata);
        end

        if (rst) begin
            m_own = OWN_NONE; m_beats = 0; m_last_d = 1'b1; m_fresh = 1'b0;
        end else if (m_own == OWN_NONE) begin
            if (dcache_wr) m_own = OWN_W;
            else if (icache_req && dcache_req) begin
`ifdef ARB_RR_EN
                m_own = m_last_d ? OWN_I : OWN_D;
`else
                m_own = OWN_D;
`endif
            end
            else if (dcache_req) m_own = OWN_D;
            else if (icache_req) m_own = OWN_I;
            m_fresh = (m_own == OWN_I) || (m_own == OWN_D);
        end else if (m_own == OWN_W) begin
            m_own = OWN_NONE; w_done = 1'b1;
        end else begin
            m_fresh = 1'b0;
            if (m_beats == NB) begin
                m_last_d = (m_own == OWN_D);
                if (m_own == OWN_I) i_done = 1'b1; else d_done = 1'b1;
                m_own = OWN_NONE; m_beats = 0; n_fills++;
            end
        end
    endtask

    // One clock cycle: drive inputs, run the model, observe outputs
    task automatic tick();
        @(negedge clk);
        rst = nx_rst; icache_req = nx_ireq; icache_addr = nx_iaddr;
        dcache_req = nx_dreq; dcache_addr = nx_daddr; dcache_wr = nx_dwr;
        dcache_wdata = nx_wdata; mem_data_valid = nx_strobe;
        model_cycle();
        #1;
        if (icache_data_valid) begin idv_cnt++; last_idv_cyc = cyc; end
        if (dcache_data_valid) ddv_cnt++;
        if (mem_wr_en) begin wr_cnt++; wr_cyc = cyc; cap_addr = mem_addr; cap_data = mem_wdata; end
        if ((icache_grant || dcache_grant) && !drv_pg) ord.push_back(icache_grant ? OWN_I : OWN_D);
        drv_pg = icache_grant || dcache_grant;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({icache_grant, dcache_grant, mem_rd_en, mem_wr_en, icache_data_valid,
                    dcache_data_valid, wr_ack, mem_addr, mem_wdata});
    endfunction

    task automatic consume_done(input bit hold);
        if (i_done) begin i_done = 1'b0; if (!hold) nx_ireq = 1'b0; end
        if (d_done) begin d_done = 1'b0; if (!hold) nx_dreq = 1'b0; end
        if (w_done) begin w_done = 1'b0; nx_dwr = 1'b0; end
    endtask

    function automatic bit strobe_at(input int n, input int period);
        if (period > 0) return (n % period) == (period - 1);
        return $urandom_range(0, 1) == 1;
    endfunction

    // Run until target fills complete and no store is pending
    task automatic run_fills(input int target, input int period, input bit hold, input int max_cyc);
        int start = n_fills;
        int n = 0;
        while ((n_fills - start) < target || nx_dwr) begin
            if (n >= max_cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL run_timeout: got %0d fills, expected %0d", n_fills - start, target);
                return;
            end
            nx_strobe = strobe_at(n, period);
            tick();
            n++;
            consume_done(hold);
        end
        nx_strobe = 1'b0;
    endtask

    // Run the current fill until it has received k beats
    task automatic run_to_beat(input int k, input int period, input int max_cyc);
        int n = 0;
        while (m_beats != k) begin
            if (n >= max_cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL beat_timeout: got %0d beats, expected %0d", m_beats, k);
                return;
            end
            nx_strobe = strobe_at(n, period);
            tick();
            n++;
        end
        nx_strobe = 1'b0;
    endtask

    // Monitor: every grant start, routed beat and store is matched to the queue
    task automatic check_ev(input int kind, input logic [6:0] sig);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d sig %b at cycle %0d, expected none", kind, sig, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.sig !== sig || e.addr !== mem_addr ||
            (kind == EV_WRITE && e.data !== mem_wdata)) begin
            n_bad++;
            $display("FAIL event: got kind %0d cyc %0d sig %b addr %h data %h, expected kind %0d cyc %0d sig %b addr %h data %h",
                     kind, cyc, sig, mem_addr, mem_wdata, e.kind, e.cyc, e.sig, e.addr, e.data);
        end
    endtask

    initial begin
        logic [6:0] s;
        bit         g;
        bit         pg = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            s = {icache_grant, dcache_grant, mem_rd_en, mem_wr_en,
                 icache_data_valid, dcache_data_valid, wr_ack};
            g = icache_grant || dcache_grant;
            if (g && !pg) check_ev(EV_GRANT, s);
            if (icache_data_valid || dcache_data_valid) check_ev(EV_BEAT, s);
            if (mem_wr_en || wr_ack) check_ev(EV_WRITE, s);
            pg = g;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        nx_rst = 1'b1; nx_ireq = 1'b0; nx_dreq = 1'b0; nx_dwr = 1'b0; nx_strobe = 1'b0;
        tick(); tick();
        nx_rst = 1'b0;
        i_done = 1'b0; d_done = 1'b0; w_done = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        chk("reset_outputs", outs(), 64'd0);

        // Single I-cache fill, strobes every 4 cycles
        idv_cnt = 0;
        nx_ireq = 1'b1; nx_iaddr = 16'h0040;
        tick();
        tick();
        chk("i_grant_latency", 64'(icache_grant), 64'd1);
        chk("i_addr_track", 64'(mem_addr), 64'h0040);
        run_fills(1, 4, 1'b0, 200);
        chk("i_beats", 64'(idv_cnt), 64'd8);
        tick();
        chk("idle_after_fill", outs(), 64'd0);

        // Both fills held high for three rounds
        do_reset();
        ord.delete();
        nx_ireq = 1'b1; nx_iaddr = 16'h0100; nx_dreq = 1'b1; nx_daddr = 16'h0200;
        run_fills(3, 2, 1'b1, 400);
        nx_ireq = 1'b0; nx_dreq = 1'b0;
        tick();
        chk("arb_rounds", 64'(ord.size()), 64'd3);
`ifdef ARB_RR_EN
        chk("arb_round0", 64'(ord[0]), 64'(OWN_I));
        chk("arb_round1", 64'(ord[1]), 64'(OWN_D));
        chk("arb_round2", 64'(ord[2]), 64'(OWN_I));
`else
        chk("arb_round0", 64'(ord[0]), 64'(OWN_D));
        chk("arb_round1", 64'(ord[1]), 64'(OWN_D));
        chk("arb_round2", 64'(ord[2]), 64'(OWN_D));
`endif

        // Store raised at beat 3 of an I fill waits for the fill
        wr_cnt = 0;
        nx_ireq = 1'b1; nx_iaddr = 16'h0040;
        run_to_beat(3, 2, 100);
        nx_dwr = 1'b1; nx_daddr = 16'h1000; nx_wdata = 16'hBEEF;
        run_fills(1, 2, 1'b0, 200);
        chk("store_cycles", 64'(wr_cnt), 64'd1);
        chk("store_addr", 64'(cap_addr), 64'h1000);
        chk("store_data", 64'(cap_data), 64'hBEEF);
        chk("store_after_fill", 64'(wr_cyc > last_idv_cyc), 64'd1);

        // Stray strobes in IDLE are dropped and do not shorten the next fill
        nx_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_strobe", 64'({icache_data_valid, dcache_data_valid}), 64'd0);
        end
        idv_cnt = 0;
        nx_ireq = 1'b1; nx_iaddr = 16'h0080;
        run_fills(1, 1, 1'b0, 100);
        chk("i_beats_after_stray", 64'(idv_cnt), 64'd8);

        // Reset at beat 5 of a D fill, then a complete fresh fill
        tick();
        nx_dreq = 1'b1; nx_daddr = 16'h2000;
        run_to_beat(5, 2, 100);
        nx_rst = 1'b1; nx_dreq = 1'b0;
        tick();
        nx_rst = 1'b0; nx_strobe = 1'b1;
        tick();
        chk("reset_mid_fill", outs(), 64'd0);
        ddv_cnt = 0;
        nx_dreq = 1'b1; nx_daddr = 16'h2040;
        run_fills(1, 2, 1'b0, 200);
        chk("d_beats_after_reset", 64'(ddv_cnt), 64'd8);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (!nx_ireq && $urandom_range(0, 3) == 0) nx_ireq = 1'b1;
            if (!nx_dreq && $urandom_range(0, 3) == 0) nx_dreq = 1'b1;
            if (!nx_dwr && $urandom_range(0, 9) == 0) begin
                nx_dwr = 1'b1; nx_wdata = DW'($urandom);
            end
            nx_iaddr = AW'($urandom);
            if (!nx_dwr || $urandom_range(0, 1) == 0) nx_daddr = AW'($urandom);
            nx_strobe = $urandom_range(0, 1) == 1;
            nx_rst = $urandom_range(0, 299) == 0;
            if (nx_rst) begin
                nx_ireq = 1'b0; nx_dreq = 1'b0; nx_dwr = 1'b0; nx_strobe = 1'b0;
            end
            tick();
            if (rst) begin i_done = 1'b0; d_done = 1'b0; w_done = 1'b0; end
            consume_done($urandom_range(0, 1) == 1);
        end
        nx_rst = 1'b0;

        // Drain outstanding requests
        for (int n = 0; n < 600; n++) begin
            if (!nx_ireq && !nx_dreq && !nx_dwr && m_own == OWN_NONE) break;
            nx_strobe = $urandom_range(0, 1) == 1;
            tick();
            consume_done(1'b0);
        end
        chk("drained", 64'({nx_ireq, nx_dreq, nx_dwr, 1'b0}), 64'd0);
        nx_strobe = 1'b0;
        tick(); tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
